// File: rtl/lb_arbiter.sv
// lb_arbiter: round-robin arbiter for the single local-bus command channel.
// Grants one requester at a time, issues its command, waits for the matching
// read-back on reads, and returns a one-cycle completion to that requester.
// Optional macro LBARB_TIMEOUT_EN: bounded read wait, completes with
// 32'hDEADBEEF and rsp_err=1 after TIMEOUT cycles in WAIT_RD.
module lb_arbiter #(
    parameter int NREQ     = 2,
    parameter int LBCWIDTH = 8,
    parameter int LBAWIDTH = 24,
    parameter int LBDWIDTH = 32,
    parameter int TIMEOUT  = 1023
) (
    input  logic                                              lbclk,
    input  logic                                              lbreset,
    input  logic [NREQ-1:0]                                   req_valid,
    input  logic [NREQ*(LBCWIDTH+LBAWIDTH+LBDWIDTH)-1:0]      req_cmd,
    output logic [NREQ-1:0]                                   req_ready,
    output logic [NREQ-1:0]                                   rsp_valid,
    output logic [LBDWIDTH-1:0]                               rsp_data,
    output logic                                              rsp_err,
    output logic [LBCWIDTH+LBAWIDTH+LBDWIDTH-1:0]             lbwcmd,
    output logic                                              lbwvalid,
    input  logic [LBCWIDTH+LBAWIDTH+LBDWIDTH-1:0]             lbrcmd,
    input  logic                                              lbrready,
    output logic                                              busy,
    output logic                                              stray
);

    localparam int W     = LBCWIDTH + LBAWIDTH + LBDWIDTH;
    localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RDBIT = LBAWIDTH + LBDWIDTH;  // cmd bit 0 position

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t                state_q;
    logic [GW-1:0]         last_q;
    logic [GW-1:0]         grant_q;
    logic [W-1:0]          lbwcmd_q;
    logic                  lbwvalid_q;
    logic [NREQ-1:0]       rsp_valid_q;
    logic [LBDWIDTH-1:0]   rsp_data_q;
    logic                  busy_q;
    logic                  stray_q;

    logic                  win_found;
    logic [GW-1:0]         win_idx;
    int                    cand;
    logic [NREQ-1:0]       grant_oh;
    logic                  addr_match;
    logic                  unused_ok;

`ifdef LBARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] TO_PATTERN = 32'hDEADBEEF;
    logic [CW-1:0]         cnt_q;
    logic                  rsp_err_q;
    logic [LBDWIDTH-1:0]   to_data;

    // Timeout data pattern, truncated or zero-extended to the data width
    always_comb begin
        to_data = '0;
        for (int b = 0; b < LBDWIDTH; b++)
            if (b < 32) to_data[b] = TO_PATTERN[b];
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Circular search upward from last_grant+1; lowest offset wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last_q) + k) % NREQ;
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = GW'(cand);
            end
        end
    end

    // Accept pulse is combinational and only ever raised in IDLE
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && win_found) req_ready[win_idx] = 1'b1;
    end

    // One-hot of the latched grant for the completion pulse
    always_comb begin
        grant_oh = '0;
        grant_oh[grant_q] = 1'b1;
    end

    assign addr_match = (lbrcmd[RDBIT-1 -: LBAWIDTH] == lbwcmd_q[RDBIT-1 -: LBAWIDTH]);
    // The read-back cmd field is not needed for matching
    assign unused_ok  = ^lbrcmd[W-1 -: LBCWIDTH];

    // Transaction FSM with all bus-side and response outputs registered
    always_ff @(posedge lbclk) begin
        if (lbreset) begin
            state_q     <= IDLE;
            last_q      <= GW'(NREQ - 1);  // requester 0 gets first priority
            grant_q     <= '0;
            lbwcmd_q    <= '0;
            lbwvalid_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            stray_q     <= 1'b0;
`ifdef LBARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            lbwvalid_q  <= 1'b0;
            rsp_valid_q <= '0;
            // Any read-back that is not the awaited one is flagged and dropped
            if (lbrready && !(state_q == WAIT_RD && addr_match)) stray_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        lbwcmd_q   <= req_cmd[win_idx*W +: W];
                        grant_q    <= win_idx;
                        last_q     <= win_idx;
                        lbwvalid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lbwcmd_q[RDBIT]) begin
                        state_q <= WAIT_RD;
`ifdef LBARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= grant_oh;
                        rsp_data_q  <= '0;
`ifdef LBARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end
                end
                WAIT_RD: begin
                    // A matching read-back beats a same-cycle expiry
                    if (lbrready && addr_match) begin
                        state_q     <= RESP;
                        rsp_valid_q <= grant_oh;
                        rsp_data_q  <= lbrcmd[LBDWIDTH-1:0];
`ifdef LBARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end
`ifdef LBARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= grant_oh;
                        rsp_data_q  <= to_data;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lbwcmd    = lbwcmd_q;
    assign lbwvalid  = lbwvalid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign stray     = stray_q;

endmodule

// File: tb/tb_lb_arbiter.sv
// tb_lb_arbiter: directed self-checking bench for lb_arbiter (NREQ=2).
module tb_lb_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 64;

    logic              lbclk = 1'b0;
    logic              lbreset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_cmd;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [W-1:0]      lbwcmd;
    logic              lbwvalid;
    logic [W-1:0]      lbrcmd;
    logic              lbrready;
    logic              busy;
    logic              stray;

    int errs   = 0;
    int checks = 0;

    lb_arbiter #(.NREQ(NREQ), .LBCWIDTH(8), .LBAWIDTH(24), .LBDWIDTH(32), .TIMEOUT(16)) dut (
        .lbclk(lbclk), .lbreset(lbreset),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .lbwcmd(lbwcmd), .lbwvalid(lbwvalid),
        .lbrcmd(lbrcmd), .lbrready(lbrready),
        .busy(busy), .stray(stray)
    );

    always #5 lbclk = ~lbclk;

    // Advance one cycle; inputs change and outputs are sampled 2ns after the edge
    task automatic tick();
        @(posedge lbclk);
        #2;
    endtask

    task automatic test_reset();
        lbreset = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (lbwvalid !== 1'b0) begin errs++; $display("FAIL reset_lbwvalid: got %b want 0", lbwvalid); end
        checks++; if (lbwcmd !== 64'h0)  begin errs++; $display("FAIL reset_lbwcmd: got %h want 0", lbwcmd); end
        checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errs++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0)  begin errs++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (stray !== 1'b0)    begin errs++; $display("FAIL reset_stray: got %b want 0", stray); end
        lbreset = 1'b0;
        tick();
        checks++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        req_cmd[0 +: W] = {8'h00, 24'h000010, 32'h12345678};
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL wr_ready_T: got %b want 01", req_ready); end
        tick();  // T+1
        req_valid = 2'b00;
        #1;
        checks++; if (lbwvalid !== 1'b1) begin errs++; $display("FAIL wr_lbwvalid: got %b want 1", lbwvalid); end
        checks++; if (lbwcmd !== 64'h0000001012345678) begin errs++; $display("FAIL wr_lbwcmd: got %h want 0000001012345678", lbwcmd); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL wr_busy: got %b want 1", busy); end
        checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL wr_rsp_early: got %b want 00", rsp_valid); end
        tick();  // T+2
        checks++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL wr_rsp_valid: got %b want 01", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errs++; $display("FAIL wr_rsp_data: got %h want 0", rsp_data); end
        checks++; if (lbwvalid !== 1'b0) begin errs++; $display("FAIL wr_lbwvalid_pulse: got %b want 0", lbwvalid); end
        tick();  // T+3
        checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL wr_rsp_pulse: got %b want 00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_idle: got %b want 0", busy); end
    endtask

    task automatic test_read();
        req_cmd[W +: W] = {8'h01, 24'h000020, 32'h00000000};
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errs++; $display("FAIL rd_ready_T: got %b want 10", req_ready); end
        tick();  // T+1
        req_valid = 2'b00;
        checks++; if (lbwvalid !== 1'b1) begin errs++; $display("FAIL rd_lbwvalid: got %b want 1", lbwvalid); end
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin errs++; $display("FAIL rd_wait_c%0d: rsp_valid %b busy %b want 00/1", c, rsp_valid, busy); end
        end
        tick();  // T+6: read-back five cycles after lbwvalid
        lbrcmd   = {8'h01, 24'h000020, 32'hCAFEF00D};
        lbrready = 1'b1;
        tick();  // T+7
        lbrready = 1'b0;
        checks++; if (rsp_valid !== 2'b10) begin errs++; $display("FAIL rd_rsp_valid: got %b want 10", rsp_valid); end
        checks++; if (rsp_data !== 32'hCAFEF00D) begin errs++; $display("FAIL rd_rsp_data: got %h want cafef00d", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
        checks++; if (stray !== 1'b0) begin errs++; $display("FAIL rd_stray: got %b want 0", stray); end
        tick();  // T+8
        checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rd_rsp_pulse: got %b want 00", rsp_valid); end
        checks++; if (rsp_data !== 32'hCAFEF00D) begin errs++; $display("FAIL rd_rsp_hold: got %h want cafef00d", rsp_data); end
    endtask

    task automatic test_contention();
        int          nleft [2];
        int          gcount;
        int          first_cyc;
        int          last_cyc;
        bit          saw_wv;
        logic [1:0]  drop;
        logic [1:0]  exp_rdy;
        nleft[0] = 4; nleft[1] = 4;
        gcount = 0; saw_wv = 1'b1; drop = 2'b00; first_cyc = 0; last_cyc = 0;
        req_cmd[0 +: W] = {8'h00, 24'h000100, 32'h00000001};
        req_cmd[W +: W] = {8'h00, 24'h000200, 32'h00000002};
        req_valid = 2'b11;
        #1;
        for (int cyc = 0; cyc < 60 && gcount < 8; cyc++) begin
            if (req_ready != 2'b00) begin
                if (gcount > 0) begin
                    checks++; if (!saw_wv) begin errs++; $display("FAIL cont_no_issue: grant %0d without lbwvalid since previous", gcount); end
                end
                exp_rdy = 2'b01 << (gcount % 2);
                checks++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL cont_order: grant %0d got %b want %b", gcount, req_ready, exp_rdy); end
                for (int i = 0; i < 2; i++)
                    if (req_ready[i]) begin
                        nleft[i]--;
                        if (nleft[i] == 0) drop[i] = 1'b1;
                    end
                if (gcount == 0) first_cyc = cyc;
                last_cyc = cyc;
                saw_wv = 1'b0;
                gcount++;
            end
            tick();
            if (lbwvalid) saw_wv = 1'b1;
            req_valid = req_valid & ~drop;
            #1;
        end
        checks++; if (gcount != 8) begin errs++; $display("FAIL cont_count: got %0d grants want 8", gcount); end
        checks++; if (last_cyc - first_cyc != 21) begin errs++; $display("FAIL cont_rate: span %0d cycles want 21", last_cyc - first_cyc); end
        req_valid = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_wrong_addr();
        req_cmd[0 +: W] = {8'h01, 24'h000020, 32'h00000000};
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL wa_ready: got %b want 01", req_ready); end
        tick();  // T+1
        req_valid = 2'b00;
        tick();  // T+2, WAIT_RD
        checks++; if (stray !== 1'b0) begin errs++; $display("FAIL wa_stray_pre: got %b want 0", stray); end
        lbrcmd   = {8'h01, 24'h000021, 32'h11111111};
        lbrready = 1'b1;
        tick();  // T+3
        lbrready = 1'b0;
        checks++; if (stray !== 1'b1) begin errs++; $display("FAIL wa_stray: got %b want 1", stray); end
        checks++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin errs++; $display("FAIL wa_still_wait: busy %b rsp_valid %b want 1/00", busy, rsp_valid); end
        tick();  // T+4
        lbrcmd   = {8'h01, 24'h000020, 32'hA5A5A5A5};
        lbrready = 1'b1;
        tick();  // T+5
        lbrready = 1'b0;
        checks++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL wa_rsp_valid: got %b want 01", rsp_valid); end
        checks++; if (rsp_data !== 32'hA5A5A5A5) begin errs++; $display("FAIL wa_rsp_data: got %h want a5a5a5a5", rsp_data); end
        repeat (2) tick();
    endtask

    task automatic test_reset_wait_rd();
        req_cmd[0 +: W] = {8'h01, 24'h000030, 32'h00000000};
        req_valid = 2'b01;
        tick();  // T+1
        req_valid = 2'b00;
        tick();  // T+2, WAIT_RD
        tick();  // T+3
        lbreset = 1'b1;
        tick();  // T+4
        lbreset = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (stray !== 1'b0) begin errs++; $display("FAIL rst_stray_clr: got %b want 0", stray); end
        checks++; if (rsp_data !== 32'h0) begin errs++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rst_no_rsp: got %b want 00", rsp_valid); end
        end
        lbrcmd   = {8'h01, 24'h000030, 32'h55AA55AA};
        lbrready = 1'b1;
        tick();
        lbrready = 1'b0;
        checks++; if (stray !== 1'b1) begin errs++; $display("FAIL rst_late_stray: got %b want 1", stray); end
        checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rst_late_rsp: got %b want 00", rsp_valid); end
        req_cmd[0 +: W] = {8'h00, 24'h000040, 32'h00000004};
        req_cmd[W +: W] = {8'h00, 24'h000050, 32'h00000005};
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errs++; $display("FAIL rst_prio: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        repeat (2) tick();
        req_valid = 2'b00;
        repeat (4) tick();
    endtask

`ifdef LBARB_TIMEOUT_EN
    task automatic test_timeout();
        req_cmd[0 +: W] = {8'h01, 24'h000060, 32'h00000000};
        req_valid = 2'b01;
        tick();  // T+1
        req_valid = 2'b00;
        for (int c = 2; c <= 17; c++) begin
            tick();
            checks++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL to_early_c%0d: got %b want 00", c, rsp_valid); end
        end
        tick();  // T+18
        checks++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL to_rsp_valid: got %b want 01", rsp_valid); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errs++; $display("FAIL to_rsp_data: got %h want deadbeef", rsp_data); end
        checks++; if (rsp_err !== 1'b1) begin errs++; $display("FAIL to_rsp_err: got %b want 1", rsp_err); end
        repeat (2) tick();
    endtask
`endif

    initial begin
        lbreset   = 1'b1;
        req_valid = '0;
        req_cmd   = '0;
        lbrcmd    = '0;
        lbrready  = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_wrong_addr();
`ifdef LBARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_wait_rd();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
